alu_md_control: RTL and testbench

//  Successor to the single-cycle ALU control decoder. It decodes opcode/Funct3/Funct7 into the ALU_Ctrl/Sub encoding,
//  and adds RV32M support: it sequences a multi-cycle multiply/divide unit with an IDLE/BUSY/DONE FSM and a latency counter.
//  It stalls the PC while an M-op is in flight. It sits between the instruction decode and the ALU / MD unit in the core.

---
 rtl/alu_md_control_if.sv | 29 ++
 rtl/alu_md_control.sv | 147 ++++++++++++++
 tb/tb_alu_md_control.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_md_control_if.sv
// rtl/alu_md_control_if.sv - decode-side bundle between instruction decode and alu_md_control
interface alu_md_control_if #(
  parameter int ALU_CTRL_W = 3
);
  logic                  EN_PC;
  logic [6:0]            opcode;
  logic [2:0]            Funct3;
  logic                  Funct7_5;
  logic                  Funct7_0;
  logic                  Flush;
  logic [ALU_CTRL_W-1:0] ALU_Ctrl;
  logic                  Sub;
  logic                  MD_Start;
  logic [2:0]            MD_Op;
  logic                  Stall;
  logic                  MD_Valid;
  logic                  WB_MD;
  logic                  Illegal;

  modport master (
    output EN_PC, opcode, Funct3, Funct7_5, Funct7_0, Flush,
    input  ALU_Ctrl, Sub, MD_Start, MD_Op, Stall, MD_Valid, WB_MD, Illegal
  );

  modport slave (
    input  EN_PC, opcode, Funct3, Funct7_5, Funct7_0, Flush,
    output ALU_Ctrl, Sub, MD_Start, MD_Op, Stall, MD_Valid, WB_MD, Illegal
  );
endinterface

// File: rtl/alu_md_control.sv
// rtl/alu_md_control.sv - ALU control decoder with RV32M multiply/divide sequencer
module alu_md_control #(
  parameter int ALU_CTRL_W = 3,
  parameter int MUL_LAT    = 2,
  parameter int DIV_LAT    = 32,
  parameter int CNT_W      = 6
) (
  input  logic              CLK,
  input  logic              rst_n,
  alu_md_control_if.slave   bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [ALU_CTRL_W-1:0] ALU_NOP = '1;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(0);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] ALU_LOG = ALU_CTRL_W'(2);
  localparam logic [ALU_CTRL_W-1:0] ALU_SHF = ALU_CTRL_W'(3);
  localparam logic [ALU_CTRL_W-1:0] ALU_BR  = ALU_CTRL_W'(4);

  // Counter is loaded with LAT-1 so that BUSY lasts exactly LAT cycles.
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       md_op_q, md_op_d;

  logic                  is_mop;
  logic                  mop_legal;
  logic                  start;
  logic [ALU_CTRL_W-1:0] base_ctrl;
  logic                  base_ill;

  assign is_mop    = bus.EN_PC && (bus.opcode == OP_R) && bus.Funct7_0;
  assign mop_legal = is_mop && !bus.Funct7_5;
  assign start     = (state_q == S_IDLE) && mop_legal && !bus.Flush;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      md_op_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      md_op_q <= md_op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_op_d = md_op_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_BUSY;
          md_op_d = bus.Funct3;
          cnt_d   = bus.Funct3[2] ? DIV_CNT : MUL_CNT;
        end
      end
      S_BUSY: begin
        if (bus.Flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (bus.Flush) cnt_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    base_ctrl = ALU_NOP;
    base_ill  = 1'b0;
    case (bus.opcode)
      OP_R, OP_IMM: begin
        case (bus.Funct3)
          3'b000:                 base_ctrl = ALU_ADD;
          3'b010, 3'b011:         base_ctrl = ALU_SLT;
          3'b100, 3'b110, 3'b111: base_ctrl = ALU_LOG;
          default:                base_ctrl = ALU_SHF;
        endcase
      end
      OP_BRANCH: base_ctrl = ALU_BR;
      OP_LOAD, OP_STORE, OP_JALR, OP_JAL, OP_LUI, OP_AUIPC: base_ctrl = ALU_ADD;
      default: base_ill = 1'b1;
    endcase
  end

  // Reset gates every output, so a reset mid-op shows no stall or result.
  always_comb begin
    bus.ALU_Ctrl = ALU_NOP;
    bus.Sub      = 1'b0;
    bus.MD_Start = 1'b0;
    bus.Stall    = 1'b0;
    bus.MD_Valid = 1'b0;
    bus.WB_MD    = 1'b0;
    bus.Illegal  = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_IDLE: begin
          if (is_mop) begin
            bus.Illegal  = bus.Funct7_5;
            bus.MD_Start = start;
            bus.Stall    = start;
          end else if (bus.EN_PC) begin
            bus.ALU_Ctrl = base_ctrl;
            bus.Illegal  = base_ill;
            bus.Sub      = (bus.opcode == OP_R) && bus.Funct7_5;
          end
        end
        S_BUSY: bus.Stall = 1'b1;
        S_DONE: begin
          bus.MD_Valid = !bus.Flush;
          bus.WB_MD    = !bus.Flush;
        end
        default: bus.Stall = 1'b0;
      endcase
    end
  end

  assign bus.MD_Op = md_op_q;

endmodule

// File: tb/tb_alu_md_control.sv
// tb/tb_alu_md_control.sv - scoreboard bench for alu_md_control
module tb_alu_md_control;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 32;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] IM = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [2:0] NOP = 3'b111;

  typedef struct packed {
    logic [2:0] alu;
    logic       sub;
    logic       start;
    logic       stall;
    logic       valid;
    logic       wb;
    logic       ill;
    logic [2:0] mdop;
  } exp_t;

  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  always #5 CLK = ~CLK;

  alu_md_control_if #(.ALU_CTRL_W(3)) bus();

  alu_md_control #(.ALU_CTRL_W(3), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  exp_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [2:0] md_last = 3'b000;

  int        f3_class[8] = '{0, 3, 1, 1, 2, 3, 2, 2};
  logic [6:0] add_ops[6] = '{7'b0000011, 7'b0100011, 7'b1100111, 7'b1101111, 7'b0110111, 7'b0010111};

  function automatic exp_t mk(input logic [2:0] alu, input logic sub, start, stall, valid, wb, ill,
                              input logic [2:0] mdop);
    exp_t e;
    e.alu = alu; e.sub = sub; e.start = start; e.stall = stall;
    e.valid = valid; e.wb = wb; e.ill = ill; e.mdop = mdop;
    return e;
  endfunction

  // Expected response when no M-op is in flight.
  function automatic exp_t idle_exp(input logic en, input logic [6:0] op, input logic [2:0] f3,
                                    input logic f75, f70, fl);
    exp_t e;
    e = mk(NOP, 0, 0, 0, 0, 0, 0, md_last);
    if (!en) return e;
    if (op == R && f70) begin
      if (f75) e.ill = 1'b1;
      else if (!fl) begin e.start = 1'b1; e.stall = 1'b1; end
      return e;
    end
    if (op == R || op == IM) begin
      e.alu = 3'(f3_class[f3]);
      e.sub = (op == R) ? f75 : 1'b0;
    end else if (op == BR) begin
      e.alu = 3'd4;
    end else begin
      e.ill = 1'b1;
      foreach (add_ops[i]) if (add_ops[i] == op) begin e.alu = 3'd0; e.ill = 1'b0; end
    end
    return e;
  endfunction

  function automatic logic [6:0] pick_op();
    int k;
    k = $urandom_range(0, 9);
    if (k < 6) return add_ops[k];
    if (k == 6) return R;
    if (k == 7) return IM;
    if (k == 8) return BR;
    return 7'($urandom);
  endfunction

  task automatic drive(input logic en, input logic [6:0] op, input logic [2:0] f3,
                       input logic f75, f70, fl);
    bus.EN_PC = en; bus.opcode = op; bus.Funct3 = f3;
    bus.Funct7_5 = f75; bus.Funct7_0 = f70; bus.Flush = fl;
  endtask

  task automatic cyc(input logic en, input logic [6:0] op, input logic [2:0] f3,
                     input logic f75, f70, fl, input exp_t e);
    @(posedge CLK); #1;
    rst_n = 1'b1;
    drive(en, op, f3, f75, f70, fl);
    sb.push_back(e);
  endtask

  task automatic cyc_rst();
    @(posedge CLK); #1;
    rst_n = 1'b0;
    drive(1'b1, R, 3'($urandom), 1'b0, 1'b1, 1'b0);
    sb.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 3'b000));
  endtask

  task automatic base(input logic en, input logic [6:0] op, input logic [2:0] f3,
                      input logic f75, f70, fl);
    cyc(en, op, f3, f75, f70, fl, idle_exp(en, op, f3, f75, f70, fl));
  endtask

  // One M-op as a whole transaction: start, LAT busy cycles, result cycle.
  task automatic run_mop(input logic [2:0] f3, input int flush_k, input int rst_k);
    int   lat;
    logic fl;
    lat = f3[2] ? DIV_LAT : MUL_LAT;
    cyc(1'b1, R, f3, 1'b0, 1'b1, 1'b0, mk(NOP, 0, 1, 1, 0, 0, 0, md_last));
    md_last = f3;
    for (int k = 1; k <= lat; k++) begin
      if (k == rst_k) begin
        cyc_rst();
        cyc_rst();
        md_last = 3'b000;
        return;
      end
      fl = (k == flush_k);
      cyc(1'($urandom), 7'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), fl,
          mk(NOP, 0, 0, 1, 0, 0, 0, md_last));
      if (fl) return;
    end
    fl = (flush_k == lat + 1);
    cyc(1'b1, R, f3, 1'b0, 1'b1, fl, mk(NOP, 0, 0, 0, !fl, !fl, 0, md_last));
  endtask

  initial begin : monitor
    exp_t e;
    exp_t a;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = {bus.ALU_Ctrl, bus.Sub, bus.MD_Start, bus.Stall, bus.MD_Valid, bus.WB_MD, bus.Illegal, bus.MD_Op};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL cycle_check t=%0t: got alu=%b sub=%b start=%b stall=%b valid=%b wb=%b ill=%b mdop=%b, want alu=%b sub=%b start=%b stall=%b valid=%b wb=%b ill=%b mdop=%b",
                   $time, a.alu, a.sub, a.start, a.stall, a.valid, a.wb, a.ill, a.mdop,
                   e.alu, e.sub, e.start, e.stall, e.valid, e.wb, e.ill, e.mdop);
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int   kind;
    logic en, f75, f70, fl;
    logic [6:0] op;
    logic [2:0] f3;
    drive(1'b0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    cyc_rst();
    cyc_rst();
    base(1, R, 3'b000, 0, 0, 0);
    base(1, R, 3'b000, 1, 0, 0);
    base(1, R, 3'b101, 1, 0, 0);
    base(1, BR, 3'b001, 1, 0, 0);
    run_mop(3'b000, -1, -1);
    run_mop(3'b101, -1, -1);
    run_mop(3'b100, 5, -1);
    run_mop(3'b000, -1, -1);
    run_mop(3'b100, -1, 7);
    base(1, IM, 3'b000, 0, 0, 0);
    base(0, R, 3'b000, 0, 1, 0);
    base(1, 7'b1111111, 3'b000, 0, 0, 0);
    base(1, R, 3'b000, 1, 1, 0);
    base(1, R, 3'b000, 0, 1, 1);
    run_mop(3'b001, MUL_LAT + 1, -1);
    run_mop(3'b011, -1, -1);
    run_mop(3'b111, DIV_LAT, -1);
    run_mop(3'b010, 1, -1);

    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 9);
      f3 = 3'($urandom);
      if (kind < 6) begin
        en = ($urandom_range(0, 7) != 0);
        op = pick_op();
        f75 = 1'($urandom); f70 = 1'($urandom); fl = ($urandom_range(0, 3) == 0);
        if (en && op == R && f70 && !f75) fl = 1'b1;
        base(en, op, f3, f75, f70, fl);
      end else if (kind == 6) begin
        run_mop(f3, -1, ($urandom_range(0, 3) == 0) ? 1 : -1);
      end else if (kind == 7) begin
        run_mop(f3, $urandom_range(1, (f3[2] ? DIV_LAT : MUL_LAT) + 1), -1);
      end else begin
        run_mop({1'b0, f3[1:0]}, -1, -1);
      end
    end

    @(negedge CLK);
    @(negedge CLK);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
